// File: rtl/instruction_decoder.sv
// Instruction register and decoder at the consumer end of the program-memory fetch path.
// Drives sequencer jump controls, NOP strobes, datapath enables/selects and the zero flag.
module instruction_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       pm_data,
    input  logic             alu_zero,
    output logic [7:0]       ir,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       jmp_addr,
    output logic             dont_jmp,
    output logic             NOPC8,
    output logic             NOPCF,
    output logic             NOPD8,
    output logic             NOPDF,
    output logic [7:0]       reg_en,
    output logic             r_en,
    output logic [3:0]       source_sel,
    output logic [3:0]       imm,
    output logic             x_sel,
    output logic             y_sel,
    output logic [2:0]       alu_func,
    output logic [CNT_W-1:0] nop_count
);

    localparam int unsigned IR_W     = 8;
    localparam logic [IR_W-1:0] IR_RESET = 8'h80;
    localparam logic [3:0]   SRC_IMM  = 4'd8;
    localparam logic [2:0]   SRC_R    = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IR_W-1:0]  ir_q, ir_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             is_load, is_move, is_alu, is_jmp, is_jnz, is_nop;
    logic [3:0]       nop_vec;
    logic [2:0]       dst, src;
    logic [7:0]       dec_reg_en;
    logic             dec_r_en, dec_jmp, dec_jnz;
    logic [3:0]       dec_nop;
    logic [3:0]       dec_src;

    // Instruction class decode
    always_comb begin
        is_load = ~ir_q[7];
        is_move = (ir_q[7:6] == 2'b10);
        is_alu  = (ir_q[7:5] == 3'b110);
        is_jmp  = (ir_q[7:4] == 4'b1110);
        is_jnz  = (ir_q[7:4] == 4'b1111);
        nop_vec = {ir_q == 8'hC8, ir_q == 8'hCF, ir_q == 8'hD8, ir_q == 8'hDF};
        is_nop  = |nop_vec;
        dst     = ir_q[5:3];
        src     = ir_q[2:0];
    end

    // Strobe and select generation; reset masks every strobe
    always_comb begin
        dec_reg_en = '0;
        dec_r_en   = 1'b0;
        dec_jmp    = 1'b0;
        dec_jnz    = 1'b0;
        dec_nop    = '0;
        dec_src    = '0;
        if (is_load) begin
            dec_reg_en[ir_q[6:4]] = 1'b1;
            dec_src               = SRC_IMM;
        end else if (is_move) begin
            dec_src = {1'b0, src};
            // A self-move is a no-op except r -> o_reg, which shares index 4
            if (!((dst == src) && (src != SRC_R))) begin
                dec_reg_en[dst] = 1'b1;
            end
        end else if (is_alu) begin
            dec_nop  = nop_vec;
            dec_r_en = ~is_nop;
        end else begin
            dec_jmp = is_jmp;
            dec_jnz = is_jnz;
        end
        if (sync_reset) begin
            dec_reg_en = '0;
            dec_r_en   = 1'b0;
            dec_jmp    = 1'b0;
            dec_jnz    = 1'b0;
            dec_nop    = '0;
        end
    end

    // Next-state: flag follows real ALU ops only, counter saturates
    always_comb begin
        ir_d   = pm_data;
        zero_d = (is_alu && !is_nop) ? alu_zero : zero_q;
        cnt_d  = cnt_q;
        if (is_nop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ir_q   <= IR_RESET;
            zero_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ir_q   <= ir_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ir         = ir_q;
    assign jmp        = dec_jmp;
    assign jmp_nz     = dec_jnz;
    assign jmp_addr   = ir_q[3:0];
    assign dont_jmp   = zero_q;
    assign NOPC8      = dec_nop[3];
    assign NOPCF      = dec_nop[2];
    assign NOPD8      = dec_nop[1];
    assign NOPDF      = dec_nop[0];
    assign reg_en     = dec_reg_en;
    assign r_en       = dec_r_en;
    assign source_sel = dec_src;
    assign imm        = ir_q[3:0];
    assign x_sel      = ir_q[4];
    assign y_sel      = ir_q[3];
    assign alu_func   = ir_q[2:0];
    assign nop_count  = cnt_q;

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
Consumer end of the program-memory fetch path. It captures the instruction word returned for pm_addr into an instruction register and decodes it. It drives the program sequencer's jump interface (jmp, jmp_nz, jmp_addr, dont_jmp) and the scrambler/queue NOP strobes (NOPC8, NOPCF, NOPD8, NOPDF). It also produces datapath register enables, source select and ALU controls, and holds the zero flag.

Parameters:
CNT_W, 8, width of the saturating NOP-executed counter

Ports:
clk  input  1  system clock, all state on rising edge
sync_reset  input  1  synchronous reset, active-high
pm_data  input  8  instruction word from program memory, sampled every clock
alu_zero  input  1  combinational ALU-result-is-zero, valid while an ALU instruction is in ir
ir  output  8  instruction register
jmp  output  1  unconditional jump strobe
jmp_nz  output  1  jump-if-not-zero strobe
jmp_addr  output  4  jump target nibble (sequencer forms {jmp_addr,4'h0})
dont_jmp  output  1  registered zero flag; sequencer suppresses jmp_nz when 1
NOPC8, NOPCF, NOPD8, NOPDF  output  1 each  NOP-code strobes
reg_en  output  8  one-hot load enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm
r_en  output  1  ALU result register load enable
source_sel  output  4  0-7 = x0,x1,y0,y1,r,m,i,dm; 8 = immediate
imm  output  4  immediate data, ir[3:0]
x_sel, y_sel  output  1 each  ALU operand selects, ir[4], ir[3]
alu_func  output  3  ALU function, ir[2:0]
nop_count  output  CNT_W  saturating count of NOP codes executed

Behaviour:
- Instruction register: ir <= pm_data on every rising edge. There is no enable and no stall. An instruction executes in the cycle it sits in ir.
- Reset: on an edge with sync_reset=1:
  - ir <= 8'h80 (self-move x0->x0, a harmless no-op).
  - zero flag <= 0.
  - nop_count <= 0.
- While sync_reset=1, every strobe is forced to 0 combinationally: jmp, jmp_nz, NOP*, reg_en, r_en.
- Decode is combinational from ir only. Field outputs (imm, x_sel, y_sel, alu_func, jmp_addr=ir[3:0]) are always driven as the raw ir bits.
- Load, ir[7]=0:
  - reg_en one-hot at ir[6:4].
  - source_sel=8.
- Move, ir[7:6]=10:
  - dst=ir[5:3], src=ir[2:0], source_sel={1'b0,src}.
  - reg_en one-hot at dst.
  - Exception: dst==src and src!=3'd4 gives reg_en=0 (self-move suppressed).
  - dst=src=4 moves r to o_reg and is valid.
- ALU, ir[7:5]=110:
  - r_en=1, reg_en=0.
  - Exception: the NOP codes 8'hC8, 8'hCF, 8'hD8, 8'hDF assert r_en=0 and assert only their own NOP strobe.
- Jump, ir[7:4]=1110: jmp=1.
- Conditional jump, ir[7:4]=1111: jmp_nz=1.
- Jumps assert no reg_en and no r_en.
- At most one of jmp, jmp_nz, NOP* is 1 in any cycle.
- Zero flag:
  - Loads on an edge where ir holds a non-NOP ALU instruction and sync_reset=0: flag <= alu_zero.
  - Otherwise the flag holds. Loads, moves, jumps and NOP codes leave it unchanged.
  - dont_jmp = flag, registered, so there is no combinational path from alu_zero to dont_jmp.
  - An ALU op immediately followed by jnz sees the updated flag.
- nop_count:
  - Increments by 1 on an edge where ir is a NOP code and sync_reset=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Reset has priority over increment.
- Reset mid-sequence: the decode outputs of the instruction in ir when reset asserts are discarded. The first post-reset edge loads 8'h80, not pm_data.

Test Plan:
1. sync_reset=1 for 2 clocks with pm_data=8'hFF -> ir=8'h80; jmp, jmp_nz, NOP*, reg_en, r_en all 0; dont_jmp=0; nop_count=0.
2. pm_data=8'h35 -> next cycle ir=8'h35, reg_en=8'b0000_1000, source_sel=8, imm=5; pm_data=8'h8D (dst1, src5) -> reg_en=8'b0000_0010, source_sel=5.
3. ir=8'hC2 with alu_zero=1 -> r_en=1; next cycle ir=8'hF7 -> jmp_nz=1, jmp_addr=7, dont_jmp=1. Repeat with alu_zero=0 -> dont_jmp=0.
4. Sequence C8, CF, D8, DF -> exactly one matching strobe per cycle, r_en=0, dont_jmp unchanged across all four, nop_count=4.
5. ir=8'h9B (y1->y1) -> reg_en=0; ir=8'hA4 (r->o_reg) -> reg_en=8'b0001_0000, source_sel=4; ir=8'hE3 -> jmp=1, jmp_addr=3.
6. CNT_W=2, five NOP codes -> nop_count 1,2,3,3,3; assert sync_reset during the next NOP -> nop_count=0, no NOP strobe that cycle.
